// File: rtl/input_stream_unpacker.sv
// Reads a layer header (count, element size) and packed payload from the input SRAM
// and streams one extended element per valid/ready transfer. UNPACK_SIGN_EXT_EN selects sign extension.
module input_stream_unpacker #(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_size,
  output logic [ADDR_W-1:0] sram_read_address,
  input  logic [DATA_W-1:0] sram_read_data,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [DATA_W-1:0] elem_data,
  output logic              elem_last,
  output logic [15:0]       elem_index
);

  typedef enum logic [2:0] {IDLE, HDR_N, HDR_S, LOAD, EMIT, FETCH, FIN} state_t;
  typedef enum logic [1:0] {SZ4, SZ8, SZ16} size_t;

  state_t            state_q;
  size_t             sz_q, sz_dec_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       n_q, idx_q, idx_inc_d;
  logic [DATA_W-1:0] word_q, data_q, ext_first_d, ext_next_d;
  logic [1:0]        lane_q, lane_inc_d, last_lane_d;
  logic              busy_q, done_q, err_q, vld_q, last_q;
  logic              sz_ok_d, is_last_elem_d, next_last_d;

  // Word layout assumes 16-bit words: lane 0 sits in the LSBs.
  function automatic logic [DATA_W-1:0] ext_lane(input logic [DATA_W-1:0] w,
                                                 input logic [1:0] lane, input size_t sz);
    logic [3:0] nib;
    logic [7:0] byt;
    nib = w[{lane, 2'b00} +: 4];
    byt = w[{lane[0], 3'b000} +: 8];
    case (sz)
`ifdef UNPACK_SIGN_EXT_EN
      SZ4:     ext_lane = {{(DATA_W-4){nib[3]}}, nib};
      SZ8:     ext_lane = {{(DATA_W-8){byt[7]}}, byt};
`else
      SZ4:     ext_lane = {{(DATA_W-4){1'b0}}, nib};
      SZ8:     ext_lane = {{(DATA_W-8){1'b0}}, byt};
`endif
      default: ext_lane = w;
    endcase
  endfunction

  always_comb begin
    sz_ok_d  = 1'b1;
    sz_dec_d = SZ16;
    case (sram_read_data)
      DATA_W'(4):  sz_dec_d = SZ4;
      DATA_W'(8):  sz_dec_d = SZ8;
      DATA_W'(16): sz_dec_d = SZ16;
      default:     sz_ok_d  = 1'b0;
    endcase
    case (sz_q)
      SZ4:     last_lane_d = 2'd3;
      SZ8:     last_lane_d = 2'd1;
      default: last_lane_d = 2'd0;
    endcase
    lane_inc_d     = lane_q + 2'd1;
    idx_inc_d      = idx_q + 16'd1;
    is_last_elem_d = (idx_q == n_q - 16'd1);
    next_last_d    = (idx_inc_d == n_q - 16'd1);
    ext_first_d    = ext_lane(sram_read_data, 2'd0, sz_q);
    ext_next_d     = ext_lane(word_q, lane_inc_d, sz_q);
  end

  // The address register leads the state by one cycle so each word lands on the state that latches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      n_q     <= '0;
      sz_q    <= SZ16;
      word_q  <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          addr_q  <= BASE_ADDR + ADDR_W'(1);
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          idx_q   <= '0;
          state_q <= HDR_N;
        end
        HDR_N: begin
          n_q     <= 16'(sram_read_data);
          addr_q  <= BASE_ADDR + ADDR_W'(2);
          state_q <= HDR_S;
        end
        HDR_S: begin
          sz_q <= sz_dec_d;
          if (!sz_ok_d || n_q == 16'd0) begin
            err_q   <= !sz_ok_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          word_q  <= sram_read_data;
          lane_q  <= '0;
          data_q  <= ext_first_d;
          vld_q   <= 1'b1;
          last_q  <= is_last_elem_d;
          state_q <= EMIT;
        end
        EMIT: if (vld_q && elem_ready) begin
          if (is_last_elem_d) begin
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q <= idx_inc_d;
            if (lane_q == last_lane_d) begin
              vld_q   <= 1'b0;
              last_q  <= 1'b0;
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= FETCH;
            end else begin
              lane_q <= lane_inc_d;
              data_q <= ext_next_d;
              last_q <= next_last_d;
            end
          end
        end
        FETCH: state_q <= LOAD;
        FIN: begin
          addr_q  <= BASE_ADDR;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err_size          = err_q;
  assign sram_read_address = addr_q;
  assign elem_valid        = vld_q;
  assign elem_data         = data_q;
  assign elem_last         = last_q;
  assign elem_index        = idx_q;

endmodule

// File: tb/tb_input_stream_unpacker.sv
// Table-driven layer tests plus stall, start-while-busy and mid-layer reset sequences,
// checked against an element scoreboard.
module tb_input_stream_unpacker;
  logic        clk = 1'b0;
  logic        reset, start, busy, done, err_size;
  logic        elem_valid, elem_ready, elem_last;
  logic [11:0] sram_read_address;
  logic [15:0] sram_read_data, elem_data, elem_index;
  logic [15:0] mem [0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) sram_read_data <= mem[sram_read_address];

  input_stream_unpacker #(.ADDR_W(12), .DATA_W(16), .BASE_ADDR(12'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err_size(err_size),
    .sram_read_address(sram_read_address), .sram_read_data(sram_read_data),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
    .elem_last(elem_last), .elem_index(elem_index));

  typedef struct packed { logic [15:0] d; logic [15:0] idx; logic last; } exp_t;
  typedef struct {
    logic [15:0]       n, s;
    logic [3:0][15:0]  w;
    logic [7:0][15:0]  ez, es;
    logic              err;
    int                lat;
    logic [11:0]       maxa;
    logic              chkmax;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  int          checks = 0, errors = 0, done_cnt = 0, vld_cnt = 0;
  logic [11:0] maxa;
  logic        hold_pend = 1'b0, hl;
  logic [15:0] hd, hi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Evaluates the current cycle (inputs already applied), then advances to #1 after the next edge.
  task automatic tick();
    exp_t e;
    if (!reset) begin
      if (hold_pend) begin
        chk("hold_valid", 32'({elem_valid, elem_last}), 32'({1'b1, hl}));
        chk("hold_data", {elem_index, elem_data}, {hi, hd});
      end
      if (elem_valid && elem_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_elem: got idx %0d data %0h, expected none", elem_index, elem_data);
        end else begin
          e = sb.pop_front();
          chk("elem_data", 32'(elem_data), 32'(e.d));
          chk("elem_index", 32'(elem_index), 32'(e.idx));
          chk("elem_last", 32'(elem_last), 32'(e.last));
        end
      end
      hold_pend = elem_valid && !elem_ready;
      hd = elem_data; hi = elem_index; hl = elem_last;
      if (done) done_cnt++;
      if (elem_valid) vld_cnt++;
      if (busy && sram_read_address > maxa) maxa = sram_read_address;
    end else begin
      hold_pend = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic load_mem(input vec_t v);
    exp_t e;
    mem[0] = v.n; mem[1] = v.s;
    for (int k = 0; k < 4; k++) mem[2+k] = v.w[k];
    for (int k = 6; k < 10; k++) mem[k] = 16'hEEEE;
    for (int i = 0; i < int'(v.n) && !v.err; i++) begin
`ifdef UNPACK_SIGN_EXT_EN
      e.d = v.es[i];
`else
      e.d = v.ez[i];
`endif
      e.idx = 16'(i);
      e.last = (i == int'(v.n) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic run_layer(input vec_t v);
    int cyc;
    load_mem(v);
    done_cnt = 0; vld_cnt = 0; maxa = '0;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("err_cleared_on_start", 32'(err_size), 0);
    cyc = 1;
    while (!done && cyc < 300) begin tick(); cyc++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
    end
    chk("done_latency", cyc, v.lat);
    chk("err_size", 32'(err_size), 32'(v.err));
    tick(); tick();
    chk("done_pulses", done_cnt, 1);
    chk("valid_cycles", vld_cnt, v.err ? 0 : int'(v.n));
    chk("all_delivered", sb.size(), 0);
    chk("busy_after_done", 32'(busy), 0);
    chk("err_sticky", 32'(err_size), 32'(v.err));
    if (v.chkmax) chk("max_read_addr", 32'(maxa), 32'(v.maxa));
    sb.delete();
  endtask

  initial begin
    int cyc, v0;
    // Element 0 is the rightmost entry of each w / ez / es concatenation.
    vecs[0] = '{n:16'd4, s:16'd8, w:{32'h0, 16'h04FF, 16'h0201},
                ez:{64'h0, 16'h0004, 16'h00FF, 16'h0002, 16'h0001},
                es:{64'h0, 16'h0004, 16'hFFFF, 16'h0002, 16'h0001},
                err:1'b0, lat:10, maxa:12'd3, chkmax:1'b1};
    vecs[1] = '{n:16'd3, s:16'd4, w:{48'h0, 16'h0F21},
                ez:{80'h0, 16'h000F, 16'h0002, 16'h0001},
                es:{80'h0, 16'hFFFF, 16'h0002, 16'h0001},
                err:1'b0, lat:7, maxa:12'd2, chkmax:1'b1};
    vecs[2] = '{n:16'd2, s:16'd16, w:{32'h0, 16'hABCD, 16'h1234},
                ez:{96'h0, 16'hABCD, 16'h1234}, es:{96'h0, 16'hABCD, 16'h1234},
                err:1'b0, lat:8, maxa:12'd3, chkmax:1'b1};
    vecs[3] = '{n:16'd0, s:16'd16, w:64'h0, ez:128'h0, es:128'h0,
                err:1'b0, lat:3, maxa:12'd0, chkmax:1'b0};
    vecs[4] = '{n:16'd2, s:16'd5, w:{32'h0, 16'h5555, 16'h5555}, ez:128'h0, es:128'h0,
                err:1'b1, lat:3, maxa:12'd0, chkmax:1'b0};
    vecs[5] = '{n:16'd1, s:16'd8, w:{48'h0, 16'h80C3},
                ez:{112'h0, 16'h00C3}, es:{112'h0, 16'hFFC3},
                err:1'b0, lat:5, maxa:12'd2, chkmax:1'b1};
    vecs[6] = '{n:16'd5, s:16'd4, w:{32'h0, 16'h0009, 16'h8765},
                ez:{48'h0, 16'h0009, 16'h0008, 16'h0007, 16'h0006, 16'h0005},
                es:{48'h0, 16'h0009, 16'hFFF8, 16'h0007, 16'h0006, 16'h0005},
                err:1'b0, lat:11, maxa:12'd3, chkmax:1'b1};

    for (int k = 0; k < 4096; k++) mem[k] = 16'h0;
    reset = 1'b1; start = 1'b0; elem_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_size), 0);
    chk("rst_valid_last", 32'({elem_valid, elem_last}), 0);
    chk("rst_data_index", {elem_index, elem_data}, 0);
    chk("rst_addr", 32'(sram_read_address), 0);
    reset = 1'b0; tick();

    for (int r = 0; r < 7; r++) run_layer(vecs[r]);

    // Stall on element 0 for 5 cycles, with a stray start in the middle.
    load_mem(vecs[2]);
    done_cnt = 0; elem_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (!elem_valid && cyc < 50) begin tick(); cyc++; end
    for (int k = 0; k < 5; k++) begin
      chk("stall_data", {15'h0, elem_valid, elem_data}, {15'h0, 1'b1, 16'h1234});
      start = (k == 2);
      tick();
    end
    start = 1'b0; elem_ready = 1'b1;
    cyc = 0;
    while (!done && cyc < 50) begin tick(); cyc++; end
    tick(); tick();
    chk("stall_done_pulses", done_cnt, 1);
    chk("stall_all_delivered", sb.size(), 0);
    v0 = vld_cnt;
    repeat (5) tick();
    chk("no_restart_busy", 32'(busy), 0);
    chk("no_restart_valid", vld_cnt, v0);
    sb.delete();

    // Reset while element 1 of a 4-element layer is on the bus.
    load_mem(vecs[0]);
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (!(elem_valid && elem_index == 16'd1) && cyc < 50) begin tick(); cyc++; end
    chk("reached_index1", 32'(elem_index), 1);
    reset = 1'b1; tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(elem_valid), 0);
    chk("midrst_index", 32'(elem_index), 0);
    chk("midrst_addr", 32'(sram_read_address), 0);
    chk("midrst_delivered_one", sb.size(), 3);
    sb.delete();
    reset = 1'b0; tick();
    run_layer(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
